// File: rtl/frame_buffer_dbl.sv
// Double-buffered (x,y)-addressed pixel store. The renderer writes the back bank while the
// scanner reads the front bank; banks swap on request, and the back bank can be hardware-cleared.
module frame_buffer_dbl #(
  parameter int               H_RES     = 320,
  parameter int               V_RES     = 240,
  parameter int               PIX_W     = 8,
  parameter logic [PIX_W-1:0] CLEAR_VAL = '0,
  parameter int               X_W       = 9,
  parameter int               Y_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             swap_req,
  output logic             swap_done,
  input  logic             clear_req,
  output logic             busy,
  output logic             front_sel
);

  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < H_RES) && (int'(y) < V_RES);
  endfunction

  function automatic logic [ADDR_W-1:0] xy2addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  logic [PIX_W-1:0] mem0 [DEPTH];
  logic [PIX_W-1:0] mem1 [DEPTH];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              front_nxt, swap_done_nxt;
  logic              pend, pend_nxt;

  // Write pipeline stage (address/bank captured at acceptance)
  logic              w_vld, w_bank;
  logic [ADDR_W-1:0] w_addr;
  logic [PIX_W-1:0]  w_data;

  // Read pipeline
  logic              rd_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic              r_vld, r_bank, r_oor;
  logic [PIX_W-1:0]  q0, q1;

  // Per-bank write port
  logic              we0, we1;
  logic [ADDR_W-1:0] wa0, wa1;
  logic [PIX_W-1:0]  wd0, wd1;

  assign busy     = (state == CLEAR);
  assign wr_ready = (state == IDLE);
  assign rd_ok    = in_range(rd_x, rd_y);
  assign rd_addr  = rd_ok ? xy2addr(rd_x, rd_y) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_vld  <= 1'b0;
      w_bank <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      w_vld  <= wr_valid & wr_ready & in_range(wr_x, wr_y);
      w_bank <= ~front_sel;
      w_addr <= xy2addr(wr_x, wr_y);
      w_data <= wr_data;
    end
  end

  // A clear word and a pipelined write can land on the same bank in the same cycle only
  // right after clear_req; the clear takes the port, matching "write, then clear" ordering.
  always_comb begin
    we0 = 1'b0; wa0 = w_addr; wd0 = w_data;
    we1 = 1'b0; wa1 = w_addr; wd1 = w_data;
    if (busy && !front_sel) begin
      we1 = 1'b1; wa1 = clr_cnt; wd1 = CLEAR_VAL;
    end else if (w_vld && w_bank) begin
      we1 = 1'b1;
    end
    if (busy && front_sel) begin
      we0 = 1'b1; wa0 = clr_cnt; wd0 = CLEAR_VAL;
    end else if (w_vld && !w_bank) begin
      we0 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem0[wa0] <= wd0;
    if (rd_en) q0 <= mem0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (we1) mem1[wa1] <= wd1;
    if (rd_en) q1 <= mem1[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= 1'b0;
      r_bank   <= 1'b0;
      r_oor    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      r_vld <= rd_en;
      if (rd_en) begin
        r_bank <= front_sel;
        r_oor  <= ~rd_ok;
      end
      rd_valid <= r_vld;
      if (r_vld) rd_data <= r_oor ? CLEAR_VAL : (r_bank ? q1 : q0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
      pend      <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      front_sel <= front_nxt;
      swap_done <= swap_done_nxt;
      pend      <= pend_nxt;
    end
  end

  // A pending swap is executed on the CLEAR->IDLE edge so it is visible in the first IDLE cycle.
  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    front_nxt     = front_sel;
    swap_done_nxt = 1'b0;
    pend_nxt      = pend;
    case (state)
      IDLE: begin
        if (swap_req || pend) begin
          front_nxt     = ~front_sel;
          swap_done_nxt = 1'b1;
          pend_nxt      = 1'b0;
        end
        if (clear_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (swap_req) pend_nxt = 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt = IDLE;
          if (pend || swap_req) begin
            front_nxt     = ~front_sel;
            swap_done_nxt = 1'b1;
            pend_nxt      = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/frame_buffer_dbl.md
Name: frame_buffer_dbl

Overview:
- Parametrised, double-buffered pixel store; successor to the single-bank 320x240x8 frame buffer.
- Renderer writes (x,y)-addressed pixels into the back bank while the display scanner reads the front bank.
- Bank swap is requested once per frame, e.g. on vsync.
- Adds coordinate-to-address translation, bounds checking, write back-pressure and a hardware back-bank clear engine.

Parameters:
H_RES, 320, horizontal pixels per frame
V_RES, 240, vertical lines per frame
PIX_W, 8, bits per pixel
CLEAR_VAL, 0, pixel value written by the clear engine (PIX_W bits)
X_W, 9, width of x coordinates; must satisfy 2**X_W >= H_RES
Y_W, 8, width of y coordinates; must satisfy 2**Y_W >= V_RES

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  block can accept a write this cycle
wr_x  in  X_W  write column
wr_y  in  Y_W  write row
wr_data  in  PIX_W  write pixel
rd_en  in  1  read request, no back-pressure
rd_x  in  X_W  read column
rd_y  in  Y_W  read row
rd_data  out  PIX_W  read pixel
rd_valid  out  1  rd_data valid this cycle
swap_req  in  1  single-cycle request to exchange front/back banks
swap_done  out  1  one-cycle pulse when the swap takes effect
clear_req  in  1  single-cycle request to fill the back bank with CLEAR_VAL
busy  out  1  clear engine active
front_sel  out  1  bank currently displayed (0 or 1)

Behaviour:
- Storage:
  - Two banks of H_RES*V_RES words, PIX_W bits each, inferred as BRAM.
  - Address = y*H_RES + x, width clog2(H_RES*V_RES).
  - Memory contents are not reset.
- Reset (async assert, sync deassert):
  - Outputs: front_sel=0, rd_data=0, rd_valid=0, swap_done=0, busy=0, wr_ready=1.
  - State = IDLE; pending swap cleared.
- Write path:
  - A write is accepted when wr_valid & wr_ready.
  - Cycle +1: address and bank registered (bank = !front_sel at acceptance).
  - Cycle +2: memory written.
  - If x >= H_RES or y >= V_RES, the write is accepted and silently dropped.
  - An in-flight write completes to its captured bank even if a swap occurs.
- Read path:
  - Fixed latency 2: rd_en at cycle N gives rd_valid=1 and rd_data at N+2.
  - rd_valid=0 in all other cycles; rd_data holds its last value.
  - Reads use front_sel as sampled at cycle N.
  - An out-of-range coordinate returns CLEAR_VAL with rd_valid=1.
  - Back-to-back reads every cycle are supported (full throughput).
- FSM states: IDLE, CLEAR.
  - IDLE:
    - wr_ready=1.
    - clear_req: go to CLEAR, clear counter=0.
    - swap_req, or a pending swap: toggle front_sel and pulse swap_done in the same cycle.
  - CLEAR:
    - busy=1, wr_ready=0.
    - Writes CLEAR_VAL to the back bank at counter, one word per cycle; counter increments.
    - After writing address H_RES*V_RES-1: go to IDLE; busy falls the following cycle.
    - Total busy duration is exactly H_RES*V_RES cycles.
    - clear_req in CLEAR: ignored.
    - swap_req in CLEAR: latched as pending; executes on the first IDLE cycle.
- Simultaneous events:
  - swap_req and clear_req together in IDLE: the swap executes first, front_sel toggles that cycle.
  - The clear then targets the new back bank (the previous front).
  - Multiple swap_req pulses during CLEAR collapse to one pending swap.
- Reset mid-clear aborts immediately; the back-bank contents are then partially cleared and undefined.

Test Plan:
1. After reset: write (5,3)=0xA5; swap_req; read (5,3) -> rd_valid two cycles after rd_en, rd_data=0xA5, front_sel=1, one swap_done pulse.
2. Before any swap: write (0,0)=0x11, read (0,0) -> returns old front content, not 0x11; out-of-range read (320,0) -> rd_data=CLEAR_VAL, rd_valid=1.
3. Issue clear_req -> busy=1 and wr_ready=0 for exactly 76800 cycles; after a swap, reads at (0,0), (319,239), (160,120) all return 0x00.
4. swap_req during clear (clear counter mid-sweep) -> front_sel unchanged until clear ends; swap_done pulses on the first IDLE cycle; a second swap_req during the same clear produces no extra toggle.
5. swap_req and clear_req in the same cycle with front_sel=0 -> front_sel=1 that cycle; the clear writes bank 0 while reads of bank 1 proceed uninterrupted.
6. rst_n asserted mid-clear -> all outputs at reset values immediately (asynchronously); FSM returns to IDLE and wr_ready=1 after deassert.
